// File: rtl/lock_input_conditioner_pkg.sv
// ----------------------------------------------------------------------------
// lock_input_conditioner_pkg
// Shared definitions between the input conditioner and the lock controller:
// the lock code width, the default debounce timebase, and the encoding of a
// debounce channel's state (SETTLED: candidate equals output, PENDING: a new
// candidate is being timed).
// ----------------------------------------------------------------------------
package lock_input_conditioner_pkg;

  localparam int LOCK_CODE_W             = 3;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int DEFAULT_CNT_W           = 20;

  typedef enum logic {
    CH_SETTLED = 1'b0,
    CH_PENDING = 1'b1
  } chan_state_t;

  // A channel is PENDING whenever its candidate differs from its output.
  function automatic chan_state_t chan_state(input logic cand_differs);
    return cand_differs ? CH_PENDING : CH_SETTLED;
  endfunction

endpackage

// File: rtl/lock_input_conditioner_debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// Synchronises a WIDTH-bit asynchronous input through SYNC_STAGES flops, then
// only passes a new value to the output once the synchronised vector has been
// identical for DEBOUNCE_CYCLES+1 consecutive samples.  Any bit moving restarts
// the window, so multi-bit inputs change as a whole vector.
//
// Ports:
//   clock   system clock
//   reset   synchronous, active-high reset (all state to 0)
//   raw     asynchronous input pins
//   level   debounced output value
//   strobe  registered one-cycle pulse, high in the cycle level takes a new value
// ----------------------------------------------------------------------------
module debounce_channel
  import lock_input_conditioner_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic             strobe
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser chain: one register per stage.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic [WIDTH-1:0] stage_reg;
    logic [WIDTH-1:0] stage_in;

    if (gi == 0) begin : g_first
      assign stage_in = raw;
    end else begin : g_next
      assign stage_in = g_sync[gi-1].stage_reg;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        stage_reg <= '0;
      end else begin
        stage_reg <= stage_in;
      end
    end
  end

  logic [WIDTH-1:0] sync_out;
  assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;

  logic [WIDTH-1:0] cand_reg,   cand_next;
  logic [WIDTH-1:0] stable_reg, stable_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             strobe_reg, strobe_next;
  chan_state_t      state;

  assign state = chan_state(cand_reg != stable_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      cand_reg   <= '0;
      stable_reg <= '0;
      cnt_reg    <= '0;
      strobe_reg <= 1'b0;
    end else begin
      cand_reg   <= cand_next;
      stable_reg <= stable_next;
      cnt_reg    <= cnt_next;
      strobe_reg <= strobe_next;
    end
  end

  always_comb begin
    cand_next   = cand_reg;
    stable_next = stable_reg;
    cnt_next    = cnt_reg;
    strobe_next = 1'b0;

    if (sync_out != cand_reg) begin
      // Input moved: take it as the new candidate and restart the window,
      // whether or not a change was already being timed.
      cand_next = sync_out;
      cnt_next  = '0;
    end else begin
      case (state)
        CH_PENDING: begin
          if (cnt_reg == CNT_LAST) begin
            stable_next = cand_reg;
            cnt_next    = '0;
            strobe_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

  assign level  = stable_reg;
  assign strobe = strobe_reg;

endmodule

// File: rtl/lock_input_conditioner.sv
// ----------------------------------------------------------------------------
// lock_input_conditioner
// Conditions the lock's raw push-button and 3-bit code switches into clean,
// clock-synchronous signals for the lock FSM.
//
// Ports:
//   clock     system clock (50 MHz)
//   reset     synchronous, active-high reset
//   pb_raw    asynchronous push-button pin
//   x_raw     asynchronous code-switch pins
//   pb_level  debounced push-button level
//   pb_pulse  one-cycle pulse on each debounced 0->1 of pb_level
//   x_code    debounced switch code, changes only as a whole vector
//   x_change  one-cycle pulse in the cycle x_code takes a new value
// ----------------------------------------------------------------------------
module lock_input_conditioner
  import lock_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,      // 2..4
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,  // >= 2
  parameter int CNT_W           = DEFAULT_CNT_W             // 2**CNT_W >= DEBOUNCE_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pb_raw,
  input  logic [LOCK_CODE_W-1:0] x_raw,
  output logic                   pb_level,
  output logic                   pb_pulse,
  output logic [LOCK_CODE_W-1:0] x_code,
  output logic                   x_change
);

  logic pb_strobe;

  debounce_channel #(
    .WIDTH           (1),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_pb (
    .clock  (clock),
    .reset  (reset),
    .raw    (pb_raw),
    .level  (pb_level),
    .strobe (pb_strobe)
  );

  debounce_channel #(
    .WIDTH           (LOCK_CODE_W),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_x (
    .clock  (clock),
    .reset  (reset),
    .raw    (x_raw),
    .level  (x_code),
    .strobe (x_change)
  );

  // Both terms are registers: the strobe coincides with the new level, so
  // gating by the level keeps only presses (0->1) and drops releases.
  assign pb_pulse = pb_strobe & pb_level;

endmodule

// File: tb/tb_lock_input_conditioner.sv
module tb_lock_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int CW   = 4;
  localparam int HIST = 4096;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       pb_raw = 1'b0;
  logic [2:0] x_raw  = 3'b000;
  logic       pb_level, pb_pulse, x_change;
  logic [2:0] x_code;

  int checks   = 0;
  int failures = 0;

  lock_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pb_raw   (pb_raw),
    .x_raw    (x_raw),
    .pb_level (pb_level),
    .pb_pulse (pb_pulse),
    .x_code   (x_code),
    .x_change (x_change)
  );

  always #5 clock = ~clock;

  // Reference model: a value sampled at edge e reaches the debounce decision
  // SYNC edges later unless a reset edge intervened (then it reads as 0).
  // The output adopts a value once DEB+1 consecutive decision samples agree
  // on it and it differs from the current output.
  int         edge_n = 0;
  logic       pb_h [HIST];
  logic [2:0] x_h  [HIST];
  logic       r_h  [HIST];
  logic       exp_pb_level = 1'b0, exp_pb_pulse = 1'b0, exp_x_change = 1'b0;
  logic [2:0] exp_x_code = 3'b000;
  logic       m_pb_rv = 1'b0;
  int         m_pb_rl = 0;
  logic [2:0] m_x_rv = 3'b000;
  int         m_x_rl = 0;

  always @(posedge clock) begin : model
    int e;
    int idx;
    bit clean;
    logic s_pb;
    logic [2:0] s_x;
    e = edge_n;
    edge_n = edge_n + 1;
    pb_h[e % HIST] = pb_raw;
    x_h[e % HIST]  = x_raw;
    r_h[e % HIST]  = reset;
    exp_pb_pulse = 1'b0;
    exp_x_change = 1'b0;
    if (reset) begin
      exp_pb_level = 1'b0;
      exp_x_code   = 3'b000;
      m_pb_rv = 1'b0; m_pb_rl = 0;
      m_x_rv  = 3'b000; m_x_rl = 0;
    end else begin
      clean = (e >= SYNC);
      for (int k = 1; k <= SYNC; k++)
        if (e - k >= 0 && r_h[(e - k) % HIST]) clean = 0;
      idx  = clean ? (e - SYNC) % HIST : 0;
      s_pb = clean ? pb_h[idx] : 1'b0;
      s_x  = clean ? x_h[idx] : 3'b000;
      if (s_pb == m_pb_rv) m_pb_rl++;
      else begin m_pb_rv = s_pb; m_pb_rl = 1; end
      if (m_pb_rl >= DEB + 1 && m_pb_rv != exp_pb_level) begin
        exp_pb_level = m_pb_rv;
        exp_pb_pulse = m_pb_rv;
      end
      if (s_x == m_x_rv) m_x_rl++;
      else begin m_x_rv = s_x; m_x_rl = 1; end
      if (m_x_rl >= DEB + 1 && m_x_rv != exp_x_code) begin
        exp_x_code   = m_x_rv;
        exp_x_change = 1'b1;
      end
    end
  end

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); reset = 1'b1; pb_raw = 1'b0; x_raw = 3'b000;
      @(posedge clock); #1;
      checks++;
      if ({pb_level, pb_pulse, x_code, x_change} !== 6'b0) begin
        failures++;
        $display("FAIL reset_hold c=%0d got=%b want=000000", c, {pb_level, pb_pulse, x_code, x_change});
      end
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      checks++;
      if ({pb_level, pb_pulse, x_code, x_change} !== 6'b0) begin
        failures++;
        $display("FAIL reset_idle c=%0d got=%b want=000000", c, {pb_level, pb_pulse, x_code, x_change});
      end
    end
    $display("test_reset: 4 reset cycles + 50 idle cycles checked");
  endtask

  task automatic test_pb_clean();
    int first_hi, first_lo, pulses, pulse_at;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b0;
      @(posedge clock); #1;
    end
    first_hi = -1; pulses = 0; pulse_at = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b1;
      @(posedge clock); #1;
      checks++;
      if ({pb_level, pb_pulse, x_code, x_change} !== {exp_pb_level, exp_pb_pulse, exp_x_code, exp_x_change}) begin
        failures++;
        $display("FAIL pb_rise_model c=%0d got=%b want=%b", c, {pb_level, pb_pulse, x_code, x_change},
                 {exp_pb_level, exp_pb_pulse, exp_x_code, exp_x_change});
      end
      if (pb_level && first_hi < 0) first_hi = c + 1;
      if (pb_pulse) begin pulses++; pulse_at = c + 1; end
    end
    checks++;
    if (first_hi != 11) begin
      failures++; $display("FAIL pb_rise_latency got=%0d want=11", first_hi);
    end
    checks++;
    if (pulses != 1 || pulse_at != 11) begin
      failures++; $display("FAIL pb_rise_pulse got count=%0d at=%0d want count=1 at=11", pulses, pulse_at);
    end
    first_lo = -1; pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b0;
      @(posedge clock); #1;
      if (!pb_level && first_lo < 0) first_lo = c + 1;
      if (pb_pulse) pulses++;
    end
    checks++;
    if (first_lo != 11 || pulses != 0) begin
      failures++; $display("FAIL pb_fall got latency=%0d pulses=%0d want latency=11 pulses=0", first_lo, pulses);
    end
    $display("test_pb_clean: rise level@%0d pulse@%0d, fall level@%0d", first_hi, pulse_at, first_lo);
  endtask

  task automatic test_pb_bounce();
    int pulses, pulse_c, highs;
    pulses = 0; pulse_c = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock); pb_raw = (c < 5) ? 1'b1 : (c < 7) ? 1'b0 : 1'b1;
      @(posedge clock); #1;
      checks++;
      if ({pb_level, pb_pulse} !== {exp_pb_level, exp_pb_pulse}) begin
        failures++;
        $display("FAIL pb_bounce_model c=%0d got=%b want=%b", c, {pb_level, pb_pulse}, {exp_pb_level, exp_pb_pulse});
      end
      if (pb_pulse) begin pulses++; pulse_c = c; end
    end
    checks++;
    if (pulses != 1 || pulse_c != 17) begin
      failures++; $display("FAIL pb_bounce_pulse got count=%0d at=%0d want count=1 at=17", pulses, pulse_c);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b0;
      @(posedge clock); #1;
    end
    highs = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock); pb_raw = (c < 5);
      @(posedge clock); #1;
      if (pb_level || pb_pulse) highs++;
    end
    checks++;
    if (highs != 0) begin
      failures++; $display("FAIL pb_glitch got active_cycles=%0d want=0", highs);
    end
    $display("test_pb_bounce: bounce pulse@%0d count=%0d, glitch active=%0d", pulse_c, pulses, highs);
  endtask

  task automatic test_x_stagger();
    int changes, chg_c;
    bit saw_010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); x_raw = 3'b000; pb_raw = 1'b0;
      @(posedge clock); #1;
    end
    changes = 0; chg_c = -1; saw_010 = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock); x_raw = (c < 4) ? 3'b010 : 3'b110;
      @(posedge clock); #1;
      checks++;
      if ({x_code, x_change} !== {exp_x_code, exp_x_change}) begin
        failures++;
        $display("FAIL x_stagger_model c=%0d got=%b want=%b", c, {x_code, x_change}, {exp_x_code, exp_x_change});
      end
      if (x_code == 3'b010) saw_010 = 1;
      if (x_change) begin changes++; chg_c = c; end
    end
    checks++;
    if (changes != 1 || chg_c != 14 || saw_010 || x_code !== 3'b110) begin
      failures++;
      $display("FAIL x_stagger got changes=%0d at=%0d saw010=%0d code=%b want changes=1 at=14 saw010=0 code=110",
               changes, chg_c, saw_010, x_code);
    end
    $display("test_x_stagger: x_change@%0d code=%b", chg_c, x_code);
  endtask

  task automatic test_reset_midwindow();
    int pulses, pulse_c, early;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b0; x_raw = 3'b000;
      @(posedge clock); #1;
    end
    pulses = 0; pulse_c = -1; early = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock); pb_raw = 1'b1; reset = (c == 5 || c == 6);
      @(posedge clock); #1;
      checks++;
      if ({pb_level, pb_pulse, x_code, x_change} !== {exp_pb_level, exp_pb_pulse, exp_x_code, exp_x_change}) begin
        failures++;
        $display("FAIL rst_mid_model c=%0d got=%b want=%b", c, {pb_level, pb_pulse, x_code, x_change},
                 {exp_pb_level, exp_pb_pulse, exp_x_code, exp_x_change});
      end
      if (c < 17 && (pb_level || pb_pulse)) early++;
      if (pb_pulse) begin pulses++; pulse_c = c; end
    end
    checks++;
    if (early != 0 || pulses != 1 || pulse_c != 17) begin
      failures++;
      $display("FAIL rst_mid got early=%0d count=%0d at=%0d want early=0 count=1 at=17", early, pulses, pulse_c);
    end
    $display("test_reset_midwindow: pulse@%0d after release", pulse_c);
  endtask

  task automatic test_simultaneous();
    int p_c, x_c, p_n, x_n;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b0; x_raw = 3'b011;
      @(posedge clock); #1;
    end
    p_c = -1; x_c = -1; p_n = 0; x_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock); pb_raw = 1'b1; x_raw = 3'b101;
      @(posedge clock); #1;
      if (pb_pulse) begin p_n++; p_c = c; end
      if (x_change) begin x_n++; x_c = c; end
    end
    checks++;
    if (p_n != 1 || x_n != 1 || p_c != 10 || x_c != 10 || x_code !== 3'b101) begin
      failures++;
      $display("FAIL simultaneous got pulse=%0d@%0d change=%0d@%0d code=%b want 1@10 1@10 code=101",
               p_n, p_c, x_n, x_c, x_code);
    end
    $display("test_simultaneous: pulse@%0d x_change@%0d", p_c, x_c);
  endtask

  task automatic test_random();
    int seg_left, rst_left, errs;
    seg_left = 0; rst_left = 0; errs = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (seg_left == 0) begin
        pb_raw   = 1'($urandom % 2);
        x_raw    = 3'($urandom % 8);
        seg_left = $urandom_range(1, 14);
      end
      seg_left--;
      if (rst_left == 0 && ($urandom % 150) == 0) rst_left = $urandom_range(1, 3);
      reset = (rst_left != 0);
      if (rst_left != 0) rst_left--;
      @(posedge clock); #1;
      checks++;
      if ({pb_level, pb_pulse, x_code, x_change} !== {exp_pb_level, exp_pb_pulse, exp_x_code, exp_x_change}) begin
        failures++; errs++;
        $display("FAIL random_model c=%0d got=%b want=%b", c, {pb_level, pb_pulse, x_code, x_change},
                 {exp_pb_level, exp_pb_pulse, exp_x_code, exp_x_change});
      end
    end
    @(negedge clock); reset = 1'b0;
    $display("test_random: 1000 cycles, %0d deviations", errs);
  endtask

  initial begin
    test_reset();
    test_pb_clean();
    test_pb_bounce();
    test_x_stagger();
    test_reset_midwindow();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
